rominit_mux: RTL and testbench
==============================

Name: rominit_mux

Overview:
- Parametrised successor to the single-byte boot/CHR ROM loader.
- Decodes the ioctl download stream into NREG address regions whose bases and sizes come from a shared table.
- Packs bytes into DW-wide words with byte enables and emits them through a valid/ready handshake. The handshake back-pressures the HPS through IOCTL_WAIT.
- Sits between the HPS ioctl bus and the boot ROM, CHR ROM and cartridge RAM writers. Reports the size loaded per region.

Parameters:
- NREG, 3: number of regions (0 = boot, 1 = chr, 2 = cart).
- DW, 16: output word width in bits; 8, 16 or 32. BPW = DW/8.
- AW, 17: region-relative byte address width.
- ROM_INDEX, 0: IOCTL_INDEX[5:0] value this block accepts; other indices are ignored entirely.

Ports:
- CLK_SYS  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- IOCTL_DOWNLOAD  in  1  download active
- IOCTL_INDEX  in  16  download index
- IOCTL_WR  in  1  byte strobe, one cycle
- IOCTL_ADDR  in  27  absolute byte address
- IOCTL_DOUT  in  8  byte data
- IOCTL_WAIT  out  1  stall HPS
- ROMINIT_SEL  out  NREG  one-hot region of the current word
- ROMINIT_ADDR  out  AW  region-relative byte address of lane 0, aligned to BPW
- ROMINIT_DATA  out  DW  packed word, lane i = byte at ADDR+i
- ROMINIT_BE  out  BPW  byte enables
- ROMINIT_VALID  out  1  word valid
- ROMINIT_READY  in  1  sink accepts word
- ROMINIT_DONE  out  1  one-cycle pulse at end of download
- ROMINIT_SIZE  out  NREG*(AW+1)  bytes written per region, highest relative address + 1

Behaviour:
- Reset values: VALID 0, WAIT 0, DONE 0, SEL 0, ADDR 0, DATA 0, BE 0, SIZE 0. State is IDLE.
- A reset mid-download discards any partial word and does not pulse DONE.
- Region decode: region r is hit when REGION_BASE[r] <= IOCTL_ADDR < REGION_BASE[r] + REGION_SIZE[r].
  - Lowest r wins on overlap.
  - No hit: the byte is dropped, no stall, SIZE unchanged.
- The accepted byte is `IOCTL_DOWNLOAD & IOCTL_WR & index match & ~IOCTL_WAIT`. The lane is the relative address mod BPW.
- FSM states: IDLE, FILL, PUSH, DONE.
- IDLE:
  - On a DOWNLOAD rising edge with index match, clear all SIZE entries and go to FILL.
- FILL: on each accepted byte in a region:
  - If the byte's region or word-aligned address differs from the held partial word (BE≠0), go to PUSH with the held word first. Keep the new byte pending and hold WAIT high so it is latched after the push.
  - Otherwise write the lane, set its BE bit and update SIZE[r] = max(SIZE[r], rel+1).
  - If the lane is BPW-1, go to PUSH the next cycle. Latency from the last byte to VALID is 1 cycle.
  - On DOWNLOAD falling: if BE≠0, go to PUSH (flush, partial BE); otherwise go to DONE.
- PUSH:
  - VALID=1 and WAIT=1; outputs are stable until READY.
  - On VALID&READY, clear BE and DATA. Then return to FILL, absorb any pending byte, or go to DONE if this was the flush.
  - When READY is high in the same cycle VALID rises, PUSH lasts exactly 1 cycle.
- DONE: DONE=1 for one cycle, then IDLE.
- WAIT is high only in PUSH or while a byte is pending. WAIT never rises in the same cycle as an accepted WR.
- DW=8: every byte pushes individually and BE is constant 1. This mode behaves as the original loader plus the handshake.
- Address beyond 2^AW inside a region: relative address wraps. Such a region entry is a configuration error; an assertion flags it.
- SIZE saturates at REGION_SIZE[r].

Decomposition:
- Package rominit_pkg:
  - REGION_BASE and REGION_SIZE constant arrays: boot 0x0000/0x1000, chr 0x1000/0x0400, cart 0x1400/0x10000.
  - Region enum REG_BOOT, REG_CHR, REG_CART.
  - State enum.
  - Function region_of(addr) returning the index plus a hit flag.
- Sub-module rominit_pack: lane write, BE tracking, aligned-address compare and flush. The top keeps the FSM, decode and SIZE.

Test Plan:
- DW=16, bytes 0x00..0x03 at addr 0..3, READY=1 -> two words: ADDR 0 DATA 0x0100 BE 11, then ADDR 2 DATA 0x0302. SEL=001, WAIT pulses 1 cycle each.
- DW=16, single byte 0xAA at 0x1000 then DOWNLOAD low -> flush word SEL=010, ADDR 0, DATA 0x00AA, BE 01. DONE pulse one cycle later, SIZE[chr]=1.
- READY held low 5 cycles during PUSH -> WAIT high 5+ cycles, outputs constant. No byte is accepted while WAIT is high.
- Byte at 0x0FFF followed by 0x1000 (DW=16) -> boot word ADDR 0xFFE BE 10 is pushed first, then chr word ADDR 0 BE 01.
- Writes at addr 0x20000 (unmapped) or IOCTL_INDEX=1 -> no VALID, no WAIT, SIZE unchanged.
- RESET asserted mid-FILL with BE=01 -> next cycle all outputs are at reset values, and no VALID or DONE is produced.

Source files
------------

// File: rtl/rominit_pkg.sv
// Shared region table, state/region enums and address decode for the ROM init mux.
package rominit_pkg;

   localparam int N_REGIONS = 3;

   // One bit wider than IOCTL_ADDR so that base + size never overflows.
   typedef logic [27:0] tab_addr_t;

   localparam tab_addr_t REGION_BASE [N_REGIONS] = '{28'h000_0000, 28'h000_1000, 28'h000_1400};
   localparam tab_addr_t REGION_SIZE [N_REGIONS] = '{28'h000_1000, 28'h000_0400, 28'h001_0000};

   typedef enum logic [1:0] {
      REG_BOOT = 2'd0,
      REG_CHR  = 2'd1,
      REG_CART = 2'd2
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_PUSH,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic    hit;
      region_e idx;
   } region_hit_t;

   // Walk from the top so the lowest matching region is the one left standing.
   function automatic region_hit_t region_of(input logic [26:0] addr);
      region_hit_t res;
      res.hit = 1'b0;
      res.idx = REG_BOOT;
      for (int r = N_REGIONS - 1; r >= 0; r--) begin
         if ({1'b0, addr} >= REGION_BASE[r] && {1'b0, addr} < REGION_BASE[r] + REGION_SIZE[r]) begin
            res.hit = 1'b1;
            res.idx = region_e'(2'(r));
         end
      end
      return res;
   endfunction

   function automatic bit cfg_fits(input int aw);
      for (int r = 0; r < N_REGIONS; r++) begin
         if (64'(REGION_SIZE[r]) > (64'd1 << aw)) return 1'b0;
      end
      return 1'b1;
   endfunction

endpackage

// File: rtl/rominit_pack.sv
// Byte-to-word packer: lane write, byte-enable tracking and the aligned-word
// compare that decides whether an incoming byte belongs to the held word.
module rominit_pack
   import rominit_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 17
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            wr,
   input  region_e         wr_region,
   input  logic [AW-1:0]   wr_rel,
   input  logic [7:0]      wr_data,
   input  region_e         cmp_region,
   input  logic [AW-1:0]   cmp_rel,
   output logic            mismatch,
   output logic [DW-1:0]   data,
   output logic [DW/8-1:0] be,
   output logic [AW-1:0]   addr,
   output region_e         region
);

   localparam int BPW = DW / 8;
   localparam logic [AW-1:0] LANE_MASK = AW'(BPW - 1);

   logic [DW-1:0]  data_n;
   logic [BPW-1:0] be_n;

   // A clear and a write in the same cycle start a fresh word holding only the new byte.
   always_comb begin
      data_n = clear ? '0 : data;
      be_n   = clear ? '0 : be;
      if (wr) begin
         for (int i = 0; i < BPW; i++) begin
            if ((wr_rel & LANE_MASK) == AW'(i)) begin
               data_n[i*8 +: 8] = wr_data;
               be_n[i]          = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data   <= '0;
         be     <= '0;
         addr   <= '0;
         region <= REG_BOOT;
      end else begin
         data <= data_n;
         be   <= be_n;
         if (wr) begin
            addr   <= wr_rel & ~LANE_MASK;
            region <= wr_region;
         end
      end
   end

   assign mismatch = (be != '0) &&
                     ((cmp_region != region) || ((cmp_rel & ~LANE_MASK) != addr));

endmodule

// File: rtl/rominit_mux.sv
// ioctl download decoder: splits the byte stream into regions, packs words and
// hands them to the ROM/RAM writers over valid/ready, stalling the HPS meanwhile.
//
// state | meaning
// IDLE  | waiting for a matching download to start
// FILL  | accepting bytes into the held word
// PUSH  | word presented on VALID, HPS stalled until READY
// DONE  | one-cycle end-of-download pulse
module rominit_mux
   import rominit_pkg::*;
#(
   parameter int NREG      = 3,
   parameter int DW        = 16,
   parameter int AW        = 17,
   parameter int ROM_INDEX = 0
) (
   input  logic                 CLK_SYS,
   input  logic                 RESET,
   input  logic                 IOCTL_DOWNLOAD,
   input  logic [15:0]          IOCTL_INDEX,
   input  logic                 IOCTL_WR,
   input  logic [26:0]          IOCTL_ADDR,
   input  logic [7:0]           IOCTL_DOUT,
   output logic                 IOCTL_WAIT,
   output logic [NREG-1:0]      ROMINIT_SEL,
   output logic [AW-1:0]        ROMINIT_ADDR,
   output logic [DW-1:0]        ROMINIT_DATA,
   output logic [DW/8-1:0]      ROMINIT_BE,
   output logic                 ROMINIT_VALID,
   input  logic                 ROMINIT_READY,
   output logic                 ROMINIT_DONE,
   output logic [NREG*(AW+1)-1:0] ROMINIT_SIZE
);

   localparam int BPW = DW / 8;
   localparam logic [AW-1:0] LANE_MASK = AW'(BPW - 1);
   localparam bit CFG_OK = cfg_fits(AW);

   state_e        state, state_n;
   logic          dl_q, ending, ending_n;
   logic          pend_valid, pend_set, pend_clr, size_clr;
   region_e       pend_region, wr_region, held_region;
   logic [AW-1:0] pend_rel, wr_rel, byte_rel;
   logic [7:0]    pend_data, wr_data;
   logic [AW:0]   size_q [NREG];
   logic [AW:0]   rel_p1, lim, size_cand;
   region_hit_t   dec;
   logic          idx_match, dl_rise, dl_fall, hit;
   logic          pack_clear, pack_wr, mismatch;

   assign dec       = region_of(IOCTL_ADDR);
   assign byte_rel  = AW'({1'b0, IOCTL_ADDR} - REGION_BASE[dec.idx]);
   assign idx_match = (IOCTL_INDEX[5:0] == 6'(ROM_INDEX));
   assign dl_rise   = IOCTL_DOWNLOAD & ~dl_q & idx_match;
   assign dl_fall   = ~IOCTL_DOWNLOAD & dl_q;

   assign IOCTL_WAIT    = (state == ST_PUSH) | pend_valid;
   assign ROMINIT_VALID = (state == ST_PUSH);
   assign ROMINIT_DONE  = (state == ST_DONE);
   assign ROMINIT_SEL   = (ROMINIT_BE != '0) ? (NREG'(1) << held_region) : '0;

   assign hit = IOCTL_DOWNLOAD & IOCTL_WR & idx_match & ~IOCTL_WAIT & dec.hit &
                (int'(dec.idx) < NREG) & (state == ST_FILL);

   always_comb begin
      state_n    = state;
      ending_n   = ending;
      pack_clear = 1'b0;
      pack_wr    = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      size_clr   = 1'b0;
      wr_region  = dec.idx;
      wr_rel     = byte_rel;
      wr_data    = IOCTL_DOUT;
      case (state)
         ST_IDLE: begin
            if (dl_rise) begin
               size_clr = 1'b1;
               ending_n = 1'b0;
               state_n  = ST_FILL;
            end
         end
         ST_FILL: begin
            if (dl_fall) begin
               if (ROMINIT_BE != '0) begin
                  ending_n = 1'b1;
                  state_n  = ST_PUSH;
               end else begin
                  state_n = ST_DONE;
               end
            end else if (hit) begin
               if (mismatch) begin
                  pend_set = 1'b1;
                  state_n  = ST_PUSH;
               end else begin
                  pack_wr = 1'b1;
                  if ((byte_rel & LANE_MASK) == LANE_MASK) state_n = ST_PUSH;
               end
            end
         end
         ST_PUSH: begin
            if (dl_fall) ending_n = 1'b1;
            if (ROMINIT_READY) begin
               pack_clear = 1'b1;
               if (pend_valid) begin
                  // The stalled byte opens the next word in the same cycle the old one leaves.
                  pack_wr   = 1'b1;
                  pend_clr  = 1'b1;
                  wr_region = pend_region;
                  wr_rel    = pend_rel;
                  wr_data   = pend_data;
                  if (((pend_rel & LANE_MASK) == LANE_MASK) || ending_n) state_n = ST_PUSH;
                  else state_n = ST_FILL;
               end else if (ending_n) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_FILL;
               end
            end
         end
         ST_DONE: begin
            ending_n = 1'b0;
            state_n  = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      rel_p1    = (AW+1)'(wr_rel) + (AW+1)'(1);
      lim       = (AW+1)'(REGION_SIZE[wr_region]);
      size_cand = (rel_p1 > lim) ? lim : rel_p1;
   end

   always_comb begin
      ROMINIT_SIZE = '0;
      for (int r = 0; r < NREG; r++) ROMINIT_SIZE[r*(AW+1) +: AW+1] = size_q[r];
   end

   // Left out of reset so a download still high when reset drops is not seen as a new start.
   always_ff @(posedge CLK_SYS) dl_q <= IOCTL_DOWNLOAD;

   always_ff @(posedge CLK_SYS) begin
      if (RESET) begin
         state       <= ST_IDLE;
         ending      <= 1'b0;
         pend_valid  <= 1'b0;
         pend_region <= REG_BOOT;
         pend_rel    <= '0;
         pend_data   <= '0;
      end else begin
         state  <= state_n;
         ending <= ending_n;
         if (pend_set) begin
            pend_valid  <= 1'b1;
            pend_region <= dec.idx;
            pend_rel    <= byte_rel;
            pend_data   <= IOCTL_DOUT;
         end else if (pend_clr) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK_SYS) begin
      for (int r = 0; r < NREG; r++) begin
         if (RESET || size_clr) size_q[r] <= '0;
         else if (pack_wr && int'(wr_region) == r && size_cand > size_q[r]) size_q[r] <= size_cand;
      end
   end

   always_ff @(posedge CLK_SYS) begin
      if (!RESET) assert (CFG_OK) else $error("rominit_mux: region table entry larger than 2**AW");
   end

   rominit_pack #(.DW(DW), .AW(AW)) u_pack (
      .clk        (CLK_SYS),
      .reset      (RESET),
      .clear      (pack_clear),
      .wr         (pack_wr),
      .wr_region  (wr_region),
      .wr_rel     (wr_rel),
      .wr_data    (wr_data),
      .cmp_region (dec.idx),
      .cmp_rel    (byte_rel),
      .mismatch   (mismatch),
      .data       (ROMINIT_DATA),
      .be         (ROMINIT_BE),
      .addr       (ROMINIT_ADDR),
      .region     (held_region)
   );

endmodule

// File: tb/tb_rominit_mux.sv
// Directed bench for rominit_mux (DW=16): vector table of single-word downloads
// plus hand sequences for word splitting, stalls, unmapped bytes and reset.
module tb_rominit_mux;

   logic        CLK_SYS = 1'b0;
   logic        RESET = 1'b1;
   logic        IOCTL_DOWNLOAD = 1'b0;
   logic [15:0] IOCTL_INDEX = 16'd0;
   logic        IOCTL_WR = 1'b0;
   logic [26:0] IOCTL_ADDR = '0;
   logic [7:0]  IOCTL_DOUT = '0;
   logic        IOCTL_WAIT;
   logic [2:0]  ROMINIT_SEL;
   logic [16:0] ROMINIT_ADDR;
   logic [15:0] ROMINIT_DATA;
   logic [1:0]  ROMINIT_BE;
   logic        ROMINIT_VALID;
   logic        ROMINIT_READY = 1'b1;
   logic        ROMINIT_DONE;
   logic [53:0] ROMINIT_SIZE;

   rominit_mux #(.NREG(3), .DW(16), .AW(17), .ROM_INDEX(0)) dut (
      .CLK_SYS        (CLK_SYS),
      .RESET          (RESET),
      .IOCTL_DOWNLOAD (IOCTL_DOWNLOAD),
      .IOCTL_INDEX    (IOCTL_INDEX),
      .IOCTL_WR       (IOCTL_WR),
      .IOCTL_ADDR     (IOCTL_ADDR),
      .IOCTL_DOUT     (IOCTL_DOUT),
      .IOCTL_WAIT     (IOCTL_WAIT),
      .ROMINIT_SEL    (ROMINIT_SEL),
      .ROMINIT_ADDR   (ROMINIT_ADDR),
      .ROMINIT_DATA   (ROMINIT_DATA),
      .ROMINIT_BE     (ROMINIT_BE),
      .ROMINIT_VALID  (ROMINIT_VALID),
      .ROMINIT_READY  (ROMINIT_READY),
      .ROMINIT_DONE   (ROMINIT_DONE),
      .ROMINIT_SIZE   (ROMINIT_SIZE)
   );

   always #5 CLK_SYS = ~CLK_SYS;

   typedef struct {
      logic [2:0]  sel;
      logic [16:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } word_t;

   typedef struct {
      int          n;
      logic [26:0] a0;
      logic [7:0]  d0;
      logic [26:0] a1;
      logic [7:0]  d1;
      logic [2:0]  sel;
      logic [16:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
      int          reg_i;
      logic [17:0] size;
   } vec_t;

   word_t words [64];
   int w_cnt = 0, done_cnt = 0, wait_cnt = 0, valid_cnt = 0;
   int checks = 0, errors = 0;

   always @(negedge CLK_SYS) begin
      if (ROMINIT_VALID && ROMINIT_READY && w_cnt < 64) begin
         words[w_cnt] = '{ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_BE};
         w_cnt++;
      end
      if (ROMINIT_DONE) done_cnt++;
      if (IOCTL_WAIT) wait_cnt++;
      if (ROMINIT_VALID) valid_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] size_of(input int r);
      return ROMINIT_SIZE[r*18 +: 18];
   endfunction

   task automatic tick();
      @(posedge CLK_SYS);
      #1;
   endtask

   task automatic start_dl(input logic [15:0] idx);
      IOCTL_INDEX = idx;
      IOCTL_DOWNLOAD = 1'b1;
      tick();
   endtask

   task automatic end_dl();
      IOCTL_DOWNLOAD = 1'b0;
      repeat (6) tick();
   endtask

   task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
      int n = 0;
      while (IOCTL_WAIT && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("wait timeout", 64'(n), 64'd0);
      IOCTL_WR = 1'b1;
      IOCTL_ADDR = a;
      IOCTL_DOUT = d;
      tick();
      IOCTL_WR = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      int w0, d0, ws0, v0;

      vecs[0] = '{2, 27'h0,     8'h00, 27'h1,   8'h01, 3'b001, 17'h0,    16'h0100, 2'b11, 0, 18'h2};
      vecs[1] = '{1, 27'h1000,  8'hAA, 27'h0,   8'h00, 3'b010, 17'h0,    16'h00AA, 2'b01, 1, 18'h1};
      vecs[2] = '{1, 27'h1401,  8'h55, 27'h0,   8'h00, 3'b100, 17'h0,    16'h5500, 2'b10, 2, 18'h2};
      vecs[3] = '{1, 27'h13FF,  8'h12, 27'h0,   8'h00, 3'b010, 17'h3FE,  16'h1200, 2'b10, 1, 18'h400};
      vecs[4] = '{2, 27'hFFE,   8'h34, 27'hFFF, 8'h56, 3'b001, 17'hFFE,  16'h5634, 2'b11, 0, 18'h1000};
      vecs[5] = '{1, 27'h113FF, 8'h77, 27'h0,   8'h00, 3'b100, 17'hFFFE, 16'h7700, 2'b10, 2, 18'h10000};

      repeat (3) tick();
      chk("reset valid", 64'(ROMINIT_VALID), 64'd0);
      chk("reset wait",  64'(IOCTL_WAIT), 64'd0);
      chk("reset done",  64'(ROMINIT_DONE), 64'd0);
      chk("reset sel",   64'(ROMINIT_SEL), 64'd0);
      chk("reset addr",  64'(ROMINIT_ADDR), 64'd0);
      chk("reset data",  64'(ROMINIT_DATA), 64'd0);
      chk("reset be",    64'(ROMINIT_BE), 64'd0);
      chk("reset size",  64'(ROMINIT_SIZE), 64'd0);
      RESET = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         w0 = w_cnt;
         d0 = done_cnt;
         start_dl(16'd0);
         wr_byte(vecs[i].a0, vecs[i].d0);
         if (vecs[i].n == 2) wr_byte(vecs[i].a1, vecs[i].d1);
         end_dl();
         chk($sformatf("vec%0d words", i), 64'(w_cnt - w0), 64'd1);
         chk($sformatf("vec%0d sel", i),  64'(words[w0].sel),  64'(vecs[i].sel));
         chk($sformatf("vec%0d addr", i), 64'(words[w0].addr), 64'(vecs[i].addr));
         chk($sformatf("vec%0d data", i), 64'(words[w0].data), 64'(vecs[i].data));
         chk($sformatf("vec%0d be", i),   64'(words[w0].be),   64'(vecs[i].be));
         chk($sformatf("vec%0d size", i), 64'(size_of(vecs[i].reg_i)), 64'(vecs[i].size));
         chk($sformatf("vec%0d done", i), 64'(done_cnt - d0), 64'd1);
      end

      // Four bytes make two full words, each pushed one cycle after its last byte.
      w0 = w_cnt; d0 = done_cnt; ws0 = wait_cnt;
      start_dl(16'd0);
      wr_byte(27'h0, 8'h00);
      wr_byte(27'h1, 8'h01);
      chk("seqA latency0", 64'(ROMINIT_VALID), 64'd1);
      wr_byte(27'h2, 8'h02);
      wr_byte(27'h3, 8'h03);
      chk("seqA latency1", 64'(ROMINIT_VALID), 64'd1);
      end_dl();
      chk("seqA words", 64'(w_cnt - w0), 64'd2);
      chk("seqA word0", {words[w0].sel, words[w0].addr, words[w0].data, words[w0].be},
          {3'b001, 17'h0, 16'h0100, 2'b11});
      chk("seqA word1", {words[w0+1].sel, words[w0+1].addr, words[w0+1].data, words[w0+1].be},
          {3'b001, 17'h2, 16'h0302, 2'b11});
      chk("seqA wait cycles", 64'(wait_cnt - ws0), 64'd2);
      chk("seqA done", 64'(done_cnt - d0), 64'd1);
      chk("seqA size", 64'(size_of(0)), 64'd4);

      // A byte for a different word forces the partial word out first.
      w0 = w_cnt; ws0 = wait_cnt;
      start_dl(16'd0);
      wr_byte(27'h0, 8'h11);
      wr_byte(27'h4, 8'h22);
      end_dl();
      chk("seqB words", 64'(w_cnt - w0), 64'd2);
      chk("seqB word0", {words[w0].sel, words[w0].addr, words[w0].data, words[w0].be},
          {3'b001, 17'h0, 16'h0011, 2'b01});
      chk("seqB word1", {words[w0+1].sel, words[w0+1].addr, words[w0+1].data, words[w0+1].be},
          {3'b001, 17'h4, 16'h0022, 2'b01});
      chk("seqB wait cycles", 64'(wait_cnt - ws0), 64'd2);
      chk("seqB size", 64'(size_of(0)), 64'd5);

      // Sink stalls for 5 cycles while the HPS keeps WR asserted for another byte.
      w0 = w_cnt; ws0 = wait_cnt;
      ROMINIT_READY = 1'b0;
      start_dl(16'd0);
      wr_byte(27'h0, 8'h10);
      wr_byte(27'h1, 8'h20);
      IOCTL_WR = 1'b1;
      IOCTL_ADDR = 27'h2;
      IOCTL_DOUT = 8'hEE;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK_SYS);
         chk($sformatf("seqC hold%0d", c),
             {ROMINIT_VALID, IOCTL_WAIT, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_BE},
             {1'b1, 1'b1, 3'b001, 17'h0, 16'h2010, 2'b11});
         tick();
      end
      ROMINIT_READY = 1'b1;
      IOCTL_WR = 1'b0;
      end_dl();
      chk("seqC words", 64'(w_cnt - w0), 64'd1);
      chk("seqC data", 64'(words[w0].data), 64'h2010);
      chk("seqC wait cycles", 64'(wait_cnt - ws0), 64'd6);
      chk("seqC size", 64'(size_of(0)), 64'd2);

      // Boot region's last byte followed by chr region's first byte.
      w0 = w_cnt;
      start_dl(16'd0);
      wr_byte(27'h0FFF, 8'hAB);
      wr_byte(27'h1000, 8'hCD);
      end_dl();
      chk("seqD words", 64'(w_cnt - w0), 64'd2);
      chk("seqD word0", {words[w0].sel, words[w0].addr, words[w0].data, words[w0].be},
          {3'b001, 17'h0FFE, 16'hAB00, 2'b10});
      chk("seqD word1", {words[w0+1].sel, words[w0+1].addr, words[w0+1].data, words[w0+1].be},
          {3'b010, 17'h0, 16'h00CD, 2'b01});
      chk("seqD size boot", 64'(size_of(0)), 64'h1000);
      chk("seqD size chr",  64'(size_of(1)), 64'd1);

      // Foreign index: ignored entirely, sizes from the last download remain.
      w0 = w_cnt; d0 = done_cnt; ws0 = wait_cnt; v0 = valid_cnt;
      start_dl(16'd1);
      wr_byte(27'h0, 8'h99);
      end_dl();
      chk("seqE idx valid", 64'(valid_cnt - v0), 64'd0);
      chk("seqE idx wait",  64'(wait_cnt - ws0), 64'd0);
      chk("seqE idx done",  64'(done_cnt - d0), 64'd0);
      chk("seqE idx size",  64'(ROMINIT_SIZE), {18'h0, 18'h1, 18'h1000});

      // Unmapped byte inside a matching download.
      d0 = done_cnt; ws0 = wait_cnt; v0 = valid_cnt;
      start_dl(16'd0);
      wr_byte(27'h20000, 8'h66);
      end_dl();
      chk("seqE unmap valid", 64'(valid_cnt - v0), 64'd0);
      chk("seqE unmap wait",  64'(wait_cnt - ws0), 64'd0);
      chk("seqE unmap size",  64'(ROMINIT_SIZE), 64'd0);
      chk("seqE unmap done",  64'(done_cnt - d0), 64'd1);

      // Reset with a partial word held.
      start_dl(16'd0);
      wr_byte(27'h0, 8'h5A);
      chk("seqF be before", 64'(ROMINIT_BE), 64'd1);
      RESET = 1'b1;
      tick();
      chk("seqF reset outs",
          {ROMINIT_VALID, IOCTL_WAIT, ROMINIT_DONE, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_BE, ROMINIT_SIZE},
          '0);
      RESET = 1'b0;
      d0 = done_cnt; v0 = valid_cnt;
      repeat (3) tick();
      end_dl();
      chk("seqF valid", 64'(valid_cnt - v0), 64'd0);
      chk("seqF done",  64'(done_cnt - d0), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
